// File: rtl/exhaustive_pattern_capture_if.sv
// Control and result bundle between the capture engine and its host.
// The engine also drives and observes the benchmark through it.
interface exhaustive_pattern_capture_if #(
   parameter int WIDTH = 4
);
   logic                start;
   logic                abort;
   logic                dut_out;
   logic [WIDTH-1:0]    dut_in;
   logic                busy;
   logic                done;
   logic [2**WIDTH-1:0] resp;
   logic [WIDTH:0]      ones;
   logic [15:0]         sig;

   modport master (
      output start, abort, dut_out,
      input  dut_in, busy, done, resp, ones, sig
   );

   modport slave (
      input  start, abort, dut_out,
      output dut_in, busy, done, resp, ones, sig
   );
endinterface

// File: rtl/exhaustive_pattern_capture.sv
// Exhaustive stimulus engine: walks every input pattern of a small benchmark
// and captures its single-bit response, ones count and CRC-16 signature.
module exhaustive_pattern_capture #(
   parameter int WIDTH  = 4,
   parameter int SETTLE = 1
) (
   input logic CK,
   input logic reset,
   exhaustive_pattern_capture_if.slave bus
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_APPLY,
      S_SAMPLE,
      S_DONE
   } state_t;

   // Pattern counter is one bit wider so the last-pattern compare cannot wrap.
   localparam logic [WIDTH:0] LAST    = (WIDTH+1)'((1 << WIDTH) - 1);
   localparam logic [3:0]     SET_END = 4'(SETTLE - 1);

   state_t              state;
   logic [WIDTH:0]      pattern;
   logic [3:0]          settle;
   logic [WIDTH-1:0]    din_q;
   logic                busy_q;
   logic                done_q;
   logic [2**WIDTH-1:0] resp_q;
   logic [WIDTH:0]      ones_q;
   logic [15:0]         sig_q;
   logic                fb;
   logic [15:0]         sig_nx;

   assign fb     = sig_q[15] ^ bus.dut_out;
   assign sig_nx = {sig_q[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);

   assign bus.dut_in = din_q;
   assign bus.busy   = busy_q;
   assign bus.done   = done_q;
   assign bus.resp   = resp_q;
   assign bus.ones   = ones_q;
   assign bus.sig    = sig_q;

   always_ff @(posedge CK) begin
      if (!reset) begin
         state   <= S_IDLE;
         pattern <= '0;
         settle  <= '0;
         din_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         resp_q  <= '0;
         ones_q  <= '0;
         sig_q   <= 16'hFFFF;
      end else begin
         done_q <= 1'b0;
         unique case (state)
            S_IDLE: begin
               if (bus.start) begin
                  state   <= S_APPLY;
                  pattern <= '0;
                  settle  <= '0;
                  din_q   <= '0;
                  busy_q  <= 1'b1;
                  resp_q  <= '0;
                  ones_q  <= '0;
                  sig_q   <= 16'hFFFF;
               end
            end
            S_APPLY: begin
               if (bus.abort) begin
                  state  <= S_IDLE;
                  busy_q <= 1'b0;
                  din_q  <= '0;
               end else begin
                  settle <= settle + 4'd1;
                  if (settle == SET_END) begin
                     state <= S_SAMPLE;
                  end
               end
            end
            S_SAMPLE: begin
               // Abort wins over capture: partial results stay as they were.
               if (bus.abort) begin
                  state  <= S_IDLE;
                  busy_q <= 1'b0;
                  din_q  <= '0;
               end else begin
                  resp_q[pattern[WIDTH-1:0]] <= bus.dut_out;
                  ones_q <= ones_q + (WIDTH+1)'(bus.dut_out);
                  sig_q  <= sig_nx;
                  if (pattern == LAST) begin
                     state  <= S_DONE;
                     busy_q <= 1'b0;
                     done_q <= 1'b1;
                     din_q  <= '0;
                  end else begin
                     state   <= S_APPLY;
                     pattern <= pattern + (WIDTH+1)'(1);
                     settle  <= '0;
                     din_q   <= din_q + WIDTH'(1);
                  end
               end
            end
            S_DONE: begin
               state <= S_IDLE;
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_exhaustive_pattern_capture.sv
// Directed bench for exhaustive_pattern_capture: two instances, one at the
// default settle time and one with SETTLE=3 and a constant-1 benchmark.
module tb_exhaustive_pattern_capture;

   logic CK;
   logic reset;
   logic mode;
   int   checks;
   int   errors;

   int          done_at;
   int          done_cnt;
   int          din_err;
   logic        s_busy;
   logic        s_done;
   logic [3:0]  s_din;
   logic [15:0] s_resp;
   logic [4:0]  s_ones;
   logic [15:0] s_sig;

   exhaustive_pattern_capture_if #(.WIDTH(4)) bus_a ();
   exhaustive_pattern_capture_if #(.WIDTH(4)) bus_b ();

   exhaustive_pattern_capture #(.WIDTH(4), .SETTLE(1)) dut_a (
      .CK    (CK),
      .reset (reset),
      .bus   (bus_a)
   );

   exhaustive_pattern_capture #(.WIDTH(4), .SETTLE(3)) dut_b (
      .CK    (CK),
      .reset (reset),
      .bus   (bus_b)
   );

   assign bus_a.dut_out = mode ? (&bus_a.dut_in) : bus_a.dut_in[0];
   assign bus_b.dut_out = 1'b1;

   initial CK = 1'b0;
   always #5 CK = ~CK;

   function automatic logic [15:0] crc_model(input logic [15:0] r);
      logic [15:0] s;
      logic        f;
      s = 16'hFFFF;
      for (int k = 0; k < 16; k++) begin
         f = s[15] ^ r[k];
         s = {s[14:0], 1'b0} ^ (f ? 16'h1021 : 16'h0000);
      end
      return s;
   endfunction

   // Starts a run and watches 120 cycles; cyc counts edges since acceptance.
   task automatic run(input bit on_b, input int ab_cyc, input int st_cyc,
                      input int rs_cyc, input int snap_cyc);
      int step;
      logic o_busy;
      logic o_done;
      logic [3:0] o_din;
      step = on_b ? 4 : 2;
      done_at = -1;
      done_cnt = 0;
      din_err = 0;
      @(negedge CK);
      if (on_b) bus_b.start = 1'b1;
      else bus_a.start = 1'b1;
      @(negedge CK);
      bus_a.start = 1'b0;
      bus_b.start = 1'b0;
      for (int cyc = 0; cyc < 120; cyc++) begin
         if (cyc > 0) @(negedge CK);
         o_busy = on_b ? bus_b.busy : bus_a.busy;
         o_done = on_b ? bus_b.done : bus_a.done;
         o_din  = on_b ? bus_b.dut_in : bus_a.dut_in;
         if (o_done === 1'b1) begin
            done_cnt++;
            if (done_at < 0) done_at = cyc;
         end
         if (ab_cyc < 0 && rs_cyc < 0 && cyc < 16 * step
             && (o_din !== 4'(cyc / step) || o_busy !== 1'b1))
            din_err++;
         if (cyc == snap_cyc) begin
            s_busy = o_busy;
            s_done = o_done;
            s_din  = o_din;
            s_resp = on_b ? bus_b.resp : bus_a.resp;
            s_ones = on_b ? bus_b.ones : bus_a.ones;
            s_sig  = on_b ? bus_b.sig : bus_a.sig;
         end
         bus_a.abort = (cyc == ab_cyc);
         bus_a.start = (cyc == st_cyc);
         reset = (cyc != rs_cyc);
      end
      bus_a.abort = 1'b0;
      bus_a.start = 1'b0;
      reset = 1'b1;
   endtask

   task automatic test_reset;
      reset = 1'b0;
      repeat (2) @(negedge CK);
      checks += 6;
      if (bus_a.dut_in !== 4'h0) begin
         errors++; $display("FAIL rst_din got %h want 0", bus_a.dut_in);
      end
      if (bus_a.busy !== 1'b0) begin
         errors++; $display("FAIL rst_busy got %b want 0", bus_a.busy);
      end
      if (bus_a.done !== 1'b0) begin
         errors++; $display("FAIL rst_done got %b want 0", bus_a.done);
      end
      if (bus_a.resp !== 16'h0000) begin
         errors++; $display("FAIL rst_resp got %h want 0000", bus_a.resp);
      end
      if (bus_a.ones !== 5'd0) begin
         errors++; $display("FAIL rst_ones got %0d want 0", bus_a.ones);
      end
      if (bus_a.sig !== 16'hFFFF) begin
         errors++; $display("FAIL rst_sig got %h want ffff", bus_a.sig);
      end
      reset = 1'b1;
   endtask

   task automatic test_lsb;
      mode = 1'b0;
      run(1'b0, -1, -1, -1, 32);
      checks += 7;
      if (done_at != 32) begin
         errors++; $display("FAIL lsb_done_at got %0d want 32", done_at);
      end
      if (done_cnt != 1) begin
         errors++; $display("FAIL lsb_done_cnt got %0d want 1", done_cnt);
      end
      if (din_err != 0) begin
         errors++; $display("FAIL lsb_din_seq got %0d bad want 0", din_err);
      end
      if (s_busy !== 1'b0) begin
         errors++; $display("FAIL lsb_busy_at_done got %b want 0", s_busy);
      end
      if (bus_a.resp !== 16'hAAAA) begin
         errors++; $display("FAIL lsb_resp got %h want aaaa", bus_a.resp);
      end
      if (bus_a.ones !== 5'd8) begin
         errors++; $display("FAIL lsb_ones got %0d want 8", bus_a.ones);
      end
      if (bus_a.sig !== crc_model(16'hAAAA)) begin
         errors++;
         $display("FAIL lsb_sig got %h want %h", bus_a.sig, crc_model(16'hAAAA));
      end
   endtask

   task automatic test_and;
      mode = 1'b1;
      run(1'b0, -1, -1, -1, -1);
      checks += 4;
      if (done_at != 32) begin
         errors++; $display("FAIL and_done_at got %0d want 32", done_at);
      end
      if (bus_a.resp !== 16'h8000) begin
         errors++; $display("FAIL and_resp got %h want 8000", bus_a.resp);
      end
      if (bus_a.ones !== 5'd1) begin
         errors++; $display("FAIL and_ones got %0d want 1", bus_a.ones);
      end
      if (bus_a.sig !== crc_model(16'h8000)) begin
         errors++;
         $display("FAIL and_sig got %h want %h", bus_a.sig, crc_model(16'h8000));
      end
      mode = 1'b0;
   endtask

   task automatic test_settle3;
      run(1'b1, -1, -1, -1, -1);
      checks += 6;
      if (done_at != 64) begin
         errors++; $display("FAIL s3_done_at got %0d want 64", done_at);
      end
      if (done_cnt != 1) begin
         errors++; $display("FAIL s3_done_cnt got %0d want 1", done_cnt);
      end
      if (din_err != 0) begin
         errors++; $display("FAIL s3_din_seq got %0d bad want 0", din_err);
      end
      if (bus_b.resp !== 16'hFFFF) begin
         errors++; $display("FAIL s3_resp got %h want ffff", bus_b.resp);
      end
      if (bus_b.ones !== 5'd16) begin
         errors++; $display("FAIL s3_ones got %0d want 16", bus_b.ones);
      end
      if (bus_b.sig !== crc_model(16'hFFFF)) begin
         errors++;
         $display("FAIL s3_sig got %h want %h", bus_b.sig, crc_model(16'hFFFF));
      end
   endtask

   task automatic test_abort;
      mode = 1'b0;
      run(1'b0, 11, -1, -1, 12);
      checks += 5;
      if (done_cnt != 0) begin
         errors++; $display("FAIL abort_done_cnt got %0d want 0", done_cnt);
      end
      if (s_busy !== 1'b0) begin
         errors++; $display("FAIL abort_busy got %b want 0", s_busy);
      end
      if (s_din !== 4'h0) begin
         errors++; $display("FAIL abort_din got %h want 0", s_din);
      end
      if (s_resp !== 16'h000A) begin
         errors++; $display("FAIL abort_resp got %h want 000a", s_resp);
      end
      if (s_ones !== 5'd2) begin
         errors++; $display("FAIL abort_ones got %0d want 2", s_ones);
      end
      run(1'b0, -1, -1, -1, -1);
      checks += 3;
      if (done_at != 32) begin
         errors++; $display("FAIL restart_done_at got %0d want 32", done_at);
      end
      if (bus_a.resp !== 16'hAAAA) begin
         errors++; $display("FAIL restart_resp got %h want aaaa", bus_a.resp);
      end
      if (bus_a.ones !== 5'd8) begin
         errors++; $display("FAIL restart_ones got %0d want 8", bus_a.ones);
      end
   endtask

   task automatic test_ignored_start;
      mode = 1'b0;
      run(1'b0, -1, 4, -1, -1);
      checks += 3;
      if (done_at != 32) begin
         errors++; $display("FAIL ign_done_at got %0d want 32", done_at);
      end
      if (done_cnt != 1) begin
         errors++; $display("FAIL ign_done_cnt got %0d want 1", done_cnt);
      end
      if (bus_a.resp !== 16'hAAAA) begin
         errors++; $display("FAIL ign_resp got %h want aaaa", bus_a.resp);
      end
   endtask

   task automatic test_reset_mid;
      mode = 1'b0;
      run(1'b0, -1, -1, 18, 19);
      checks += 7;
      if (s_busy !== 1'b0) begin
         errors++; $display("FAIL mid_busy got %b want 0", s_busy);
      end
      if (s_din !== 4'h0) begin
         errors++; $display("FAIL mid_din got %h want 0", s_din);
      end
      if (s_done !== 1'b0) begin
         errors++; $display("FAIL mid_done got %b want 0", s_done);
      end
      if (s_resp !== 16'h0000) begin
         errors++; $display("FAIL mid_resp got %h want 0000", s_resp);
      end
      if (s_ones !== 5'd0) begin
         errors++; $display("FAIL mid_ones got %0d want 0", s_ones);
      end
      if (s_sig !== 16'hFFFF) begin
         errors++; $display("FAIL mid_sig got %h want ffff", s_sig);
      end
      if (done_cnt != 0) begin
         errors++; $display("FAIL mid_done_cnt got %0d want 0", done_cnt);
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      mode = 1'b0;
      reset = 1'b0;
      bus_a.start = 1'b0;
      bus_a.abort = 1'b0;
      bus_b.start = 1'b0;
      bus_b.abort = 1'b0;
      test_reset();
      test_lsb();
      test_and();
      test_settle3();
      test_abort();
      test_ignored_start();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/exhaustive_pattern_capture.md
# exhaustive_pattern_capture

On-chip exhaustive stimulus and response-capture engine for the small trojan-detection benchmark circuits. It drives every input pattern 0 … 2^WIDTH−1, in ascending order, into a benchmark DUT with a single-bit output. After a settle time it samples the DUT output for each pattern and builds a full response vector, a ones count and a CRC-16 signature. It replaces the file-writing bench loop in hardware regression, and sits directly upstream (`dut_in`) and downstream (`dut_out`) of the benchmark instance.

## Interface
- `WIDTH`, 4, number of DUT input bits; legal range 1..8.
- `SETTLE`, 1, cycles a pattern is held before its sample cycle; legal range 1..15.

- `CK`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  reset; synchronous, active-low.
- `start`  in  1  run request; accepted only in IDLE.
- `abort`  in  1  synchronous run cancel.
- `dut_out`  in  1  benchmark output, combinational from `dut_in`.
- `dut_in`  out  WIDTH  current pattern driven to the benchmark.
- `busy`  out  1  high in APPLY and SAMPLE.
- `done`  out  1  one-cycle pulse when a run completes.
- `resp`  out  2**WIDTH  bit k = `dut_out` sampled for pattern k.
- `ones`  out  WIDTH+1  number of 1s in `resp`.
- `sig`  out  16  CRC-16-CCITT signature of the responses, pattern 0 first.

## Operation
- **Reset** (`reset`=0 at an edge):
  - state IDLE.
  - `dut_in`=0, `busy`=0, `done`=0.
  - `resp`=0, `ones`=0, `sig`=16'hFFFF.
  - Internal pattern and settle counters = 0.
- **States:** IDLE, APPLY, SAMPLE, DONE.
- **IDLE** → APPLY when `start`=1. On this transition:
  - pattern = 0, settle counter = 0.
  - `resp`=0, `ones`=0, `sig`=16'hFFFF.
- **APPLY:** `dut_in` = pattern.
  - The settle counter increments each cycle.
  - After SETTLE cycles in APPLY, go to SAMPLE.
- **SAMPLE:** `dut_in` = pattern. At the closing edge:
  - `resp[pattern]` ← `dut_out`.
  - `ones` += `dut_out`.
  - CRC update: fb = `sig[15]` ^ `dut_out`; `sig` ← {`sig[14:0]`,0} ^ (fb ? 16'h1021 : 0).
  - If pattern = 2^WIDTH−1, go to DONE. Otherwise pattern += 1, settle counter = 0, go to APPLY.
- **DONE:** `done`=1 for exactly this cycle; then IDLE unconditionally.
- **`dut_in` when not busy:** 0 in IDLE and DONE.
- **Result hold:** `resp`, `ones` and `sig` hold their values from DONE until the next accepted `start`.
- **`start` outside IDLE:** ignored in APPLY, SAMPLE and DONE. It is not queued.
- **`abort`=1 in APPLY or SAMPLE:**
  - Next state IDLE; no `done` pulse.
  - `dut_in`=0.
  - Partial results hold and are invalid.
  - `abort` has priority over SAMPLE capture in the same cycle; no capture is made.
- **`abort` in IDLE or DONE:** no effect. The DONE pulse still completes.
- **`start` and `abort` together in IDLE:** start is accepted. Abort has no effect in IDLE.
- **`reset` mid-run:** all reset values apply at that edge. The run is lost.
- **Arithmetic:** the pattern counter is WIDTH+1 bits internally so the last-pattern compare has no wrap. `ones` cannot overflow because its maximum is 2^WIDTH.

## Timing
- **Start acceptance:** `start` sampled high in IDLE at edge E0. `busy` and `dut_in`=0 are visible from E0 onward.
- **Per pattern:** SETTLE+1 cycles. The pattern is stable for SETTLE+1 cycles before its capture edge.
- **`done`:** high in the cycle after edge E0 + 2^WIDTH·(SETTLE+1). Defaults: cycle following E0+32.
- **Results valid:** from the `done` cycle onward.
- **Busy-to-done gap:** `busy` falls in the same cycle `done` rises.
- **Idle to next run:** minimum 1 IDLE cycle between `done` and the next acceptable `start`.
- **Abort latency:** `busy`=0 and `dut_in`=0 one edge after `abort` is sampled.

## Test plan
- **Reset values:** hold `reset`=0 for 2 cycles → `dut_in`=0, `busy`=0, `done`=0, `resp`=0, `ones`=0, `sig`=16'hFFFF.
- **Run with `dut_out` = `dut_in[0]`** (defaults):
  - `resp`=16'hAAAA, `ones`=8.
  - `done` pulses exactly once, 33 cycles after start acceptance.
  - `dut_in` steps 0..15 in order, each held 2 cycles.
- **Run with `dut_out` = AND of all `dut_in` bits:** `resp`=16'h8000, `ones`=1. `sig` matches the bit-serial CRC-16-CCITT model seeded FFFF.
- **Run with `dut_out` tied 1, SETTLE=3:** `resp`=16'hFFFF, `ones`=16. `done` arrives 65 cycles after acceptance.
- **Abort and restart:**
  - Assert `abort` in the SAMPLE cycle of pattern 5 → no `done`, `busy`=0 next cycle, `resp[5]` not written.
  - A following `start` runs cleanly to the expected `resp`.
- **Ignored start and reset mid-run:**
  - `start` pulsed during APPLY → ignored; run length unchanged.
  - `reset`=0 at pattern 9 → all outputs at reset values the next cycle. No `done` follows.
